// File: rtl/instr_exec_unit.sv
// Multi-cycle execute stage: 8x16 register file, 8-op ALU, one-cycle done pulse.
// Optional debug read port is enabled by defining INSTR_EXEC_DEBUG_EN.
module instr_exec_unit #(
    parameter int NUM_REGS = 8,
    parameter int DATA_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run_core,
    input  logic [15:0]       instr,
`ifdef INSTR_EXEC_DEBUG_EN
    input  logic [2:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data,
`endif
    output logic              done,
    output logic [DATA_W-1:0] last_alu_result,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH_A = 2'd1,
        EXEC    = 2'd2,
        WRITE   = 2'd3
    } state_t;

    state_t            state;
    logic [15:0]       ir;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] alu_q;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] regs [NUM_REGS];

    logic [1:0] fmt;
    logic [2:0] rx;
    logic [2:0] ry;
    logic [7:0] imm8;
    logic [2:0] sel;

    assign fmt  = ir[1:0];
    assign rx   = ir[15:13];
    assign ry   = ir[12:10];
    assign imm8 = ir[12:5];
    assign sel  = ir[4:2];

    always_comb begin
        alu_res = '0;
        case (sel)
            3'd0: alu_res = a_q + b_q;
            3'd1: alu_res = a_q - b_q;
            3'd2: alu_res = a_q & b_q;
            3'd3: alu_res = a_q | b_q;
            3'd4: alu_res = a_q ^ b_q;
            3'd5: alu_res = a_q << b_q[3:0];
            3'd6: alu_res = a_q >> b_q[3:0];
            default: begin
                if (a_q == b_q)
                    alu_res = DATA_W'(0);
                else if (a_q > b_q)
                    alu_res = DATA_W'(1);
                else
                    alu_res = DATA_W'(2);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            done            <= 1'b0;
            busy            <= 1'b0;
            last_alu_result <= '0;
            ir              <= '0;
            a_q             <= '0;
            b_q             <= '0;
            alu_q           <= '0;
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (run_core) begin
                        ir    <= instr;
                        busy  <= 1'b1;
                        state <= FETCH_A;
                    end
                end
                FETCH_A: begin
                    a_q <= regs[rx];
                    b_q <= (fmt == 2'b00) ? regs[ry] : {{(DATA_W-8){1'b0}}, imm8};
                    // branch and reserved formats skip the ALU entirely
                    state <= fmt[1] ? WRITE : EXEC;
                end
                EXEC: begin
                    alu_q <= alu_res;
                    state <= WRITE;
                end
                WRITE: begin
                    if (!fmt[1]) begin
                        regs[rx]        <= alu_q;
                        last_alu_result <= alu_q;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef INSTR_EXEC_DEBUG_EN
    assign dbg_data = regs[dbg_sel];
`endif

endmodule
